dram_bist_master: RTL and testbench

Wishbone master built-in self-test for the DRAM controller. It writes a pseudo-random pattern to a configurable address range through the controller's 128-bit Wishbone slave port, waits a settling gap, then reads the range back and compares it. It reports pass/fail, the error count and the first failing address. It sits directly upstream of `DRAM_Controller` in the board top, replacing the single-word test sequencer. It runs on the user clock domain.

---
 rtl/dram_bist_pkg.sv | 42 ++++
 rtl/lfsr32.sv | 18 +
 rtl/dram_bist_master.sv | 160 ++++++++++++++++
 tb/tb_dram_bist_master.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_bist_pkg.sv
// Shared types and pattern helpers for the DRAM Wishbone BIST master.
// Words are built as 32-bit lanes derived from one Galois LFSR value.
package dram_bist_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_CALIB,
        WR_REQ,
        WR_GAP,
        GAP,
        RD_REQ,
        RD_GAP,
        CHECK,
        DONE
    } bist_state_t;

    localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
    // Widest word bist_pattern can build; callers truncate to their width.
    localparam int          MAX_WORD_SIZE = 512;

    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_POLY : 32'h0);
    endfunction

    // Lane k = rotl(lfsr, 8k mod 32) ^ (0x01010101 * k).
    function automatic logic [MAX_WORD_SIZE-1:0] bist_pattern(input logic [31:0] lfsr,
                                                              input int word_size);
        logic [MAX_WORD_SIZE-1:0] p;
        logic [4:0]               sh;
        logic [31:0]              rot;
        p = '0;
        for (int k = 0; k < MAX_WORD_SIZE / 32; k++) begin
            if (k < word_size / 32) begin
                sh  = 5'(8 * k);
                rot = (lfsr << sh) | (lfsr >> (6'd32 - {1'b0, sh}));
                p[32*k +: 32] = rot ^ (32'h0101_0101 * 32'(k));
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit right-shifting Galois LFSR; load has priority over step.
module lfsr32
    import dram_bist_pkg::*;
(
    input  logic        user_clk_i,
    input  logic        rst_i,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] q
);

    always_ff @(posedge user_clk_i) begin
        if (rst_i || load) q <= seed;
        else if (step)     q <= lfsr_next(q);
    end

endmodule

// File: rtl/dram_bist_master.sv
// Wishbone BIST master: writes an LFSR pattern over an address range, idles,
// reads it back and reports error count, first failing address and timeout.
module dram_bist_master
    import dram_bist_pkg::*;
#(
    parameter int          WORD_SIZE      = 128,
    parameter int          NUM_WORDS      = 1024,
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP      = 32'h10,
    parameter int          GAP_CYCLES     = 5000,
    parameter int          TIMEOUT_CYCLES = 65535,
    parameter logic [31:0] SEED           = 32'hACE1_2468
) (
    input  logic                 user_clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 calib_done_i,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [31:0]          addr_o,
    output logic [WORD_SIZE-1:0] data_o,
    input  logic [WORD_SIZE-1:0] data_i,
    input  logic                 ack_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 fail_o,
    output logic                 timeout_o,
    output logic [15:0]          err_count_o,
    output logic [31:0]          first_err_addr_o
);

    localparam int IDX_W = $clog2(NUM_WORDS + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    // GAP_CYCLES and TIMEOUT_CYCLES are expected to be >= 1.
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    bist_state_t          state_q, state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [GAP_W-1:0]     gap_q;
    logic [WD_W-1:0]      wd_q;
    logic [31:0]          lfsr_q;
    logic [WORD_SIZE-1:0] rd_q, exp_q, pattern;
    logic [15:0]          err_q;
    logic [31:0]          first_q, cur_addr;
    logic                 timeout_q;

    logic start_ok, in_req, wd_expired, gap_end, mismatch, lfsr_load, lfsr_step;

    assign start_ok   = start_i && (state_q == IDLE || state_q == DONE);
    assign in_req     = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign wd_expired = in_req && !ack_i && (wd_q == WD_LAST);
    assign gap_end    = (state_q == GAP) && (gap_q == GAP_LAST);
    assign mismatch   = rd_q != exp_q;
    assign cur_addr   = ADDR_BASE + ADDR_STEP * 32'(idx_q);
    assign pattern    = WORD_SIZE'(bist_pattern(lfsr_q, WORD_SIZE));
    assign lfsr_load  = start_ok || gap_end;
    assign lfsr_step  = (state_q == WR_REQ && ack_i) || (state_q == CHECK);

    lfsr32 u_lfsr (
        .user_clk_i (user_clk_i),
        .rst_i      (rst_i),
        .load       (lfsr_load),
        .seed       (SEED),
        .step       (lfsr_step),
        .q          (lfsr_q)
    );

    always_ff @(posedge user_clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start_i) state_d = WAIT_CALIB;
            WAIT_CALIB: if (calib_done_i) state_d = WR_REQ;
            WR_REQ: begin
                if (ack_i)           state_d = WR_GAP;
                else if (wd_expired) state_d = DONE;
            end
            WR_GAP:     state_d = (idx_q == IDX_END) ? GAP : WR_REQ;
            GAP:        if (gap_end) state_d = RD_REQ;
            RD_REQ: begin
                if (ack_i)           state_d = CHECK;
                else if (wd_expired) state_d = DONE;
            end
            CHECK:      state_d = (idx_q == IDX_LAST) ? DONE : RD_GAP;
            RD_GAP:     state_d = RD_REQ;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        cyc_o  = 1'b0;
        stb_o  = 1'b0;
        we_o   = 1'b0;
        busy_o = 1'b1;
        done_o = 1'b0;
        unique case (state_q)
            IDLE:   busy_o = 1'b0;
            WR_REQ: begin cyc_o = 1'b1; stb_o = 1'b1; we_o = 1'b1; end
            RD_REQ: begin cyc_o = 1'b1; stb_o = 1'b1; end
            DONE:   begin busy_o = 1'b0; done_o = 1'b1; end
            default: ;
        endcase
    end

    // Address/data are forced to 0 off-bus so idle and reset outputs read as 0.
    assign addr_o           = stb_o ? cur_addr : '0;
    assign data_o           = we_o ? pattern : '0;
    assign pass_o           = done_o && (err_q == 16'd0) && !timeout_q;
    assign fail_o           = done_o && !pass_o;
    assign timeout_o        = timeout_q;
    assign err_count_o      = err_q;
    assign first_err_addr_o = first_q;

    always_ff @(posedge user_clk_i) begin
        if (rst_i) begin
            idx_q     <= '0;
            gap_q     <= '0;
            wd_q      <= '0;
            rd_q      <= '0;
            exp_q     <= '0;
            err_q     <= '0;
            first_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q  <= in_req ? wd_q + 1'b1 : '0;
            gap_q <= (state_q == GAP) ? gap_q + 1'b1 : '0;
            if (start_ok) begin
                idx_q     <= '0;
                err_q     <= '0;
                first_q   <= '0;
                timeout_q <= 1'b0;
            end
            if (state_q == WR_REQ && ack_i) idx_q <= idx_q + 1'b1;
            if (gap_end) idx_q <= '0;
            if (state_q == RD_REQ && ack_i) begin
                rd_q  <= data_i;
                exp_q <= pattern;
            end
            if (state_q == CHECK) begin
                idx_q <= idx_q + 1'b1;
                if (mismatch) begin
                    if (err_q != 16'hFFFF) err_q <= err_q + 1'b1;
                    if (err_q == 16'd0)    first_q <= cur_addr;
                end
            end
            if (wd_expired) timeout_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dram_bist_master.sv
// Bench for dram_bist_master: Wishbone memory model with scoreboard plus
// a table of run scenarios and hand sequences for calib/start/reset cases.
module tb_dram_bist_master;

    localparam logic [31:0] TB_SEED = 32'hACE1_2468;
    localparam int          NW      = 8;

    logic         user_clk_i = 1'b0;
    logic         rst_i = 1'b1, start_i = 1'b0, calib_done_i = 1'b1, ack_i = 1'b0;
    logic         cyc_o, stb_o, we_o, busy_o, done_o, pass_o, fail_o, timeout_o;
    logic [31:0]  addr_o, first_err_addr_o;
    logic [127:0] data_o, data_i = '0;
    logic [15:0]  err_count_o;

    always #5 user_clk_i = ~user_clk_i;

    dram_bist_master #(
        .WORD_SIZE(128), .NUM_WORDS(NW), .GAP_CYCLES(20), .TIMEOUT_CYCLES(50)
    ) dut (
        .user_clk_i(user_clk_i), .rst_i(rst_i), .start_i(start_i), .calib_done_i(calib_done_i),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .addr_o(addr_o), .data_o(data_o),
        .data_i(data_i), .ack_i(ack_i), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .fail_o(fail_o), .timeout_o(timeout_o), .err_count_o(err_count_o),
        .first_err_addr_o(first_err_addr_o)
    );

    typedef struct {
        int          lat, e1w, e1b, e2w, e2b, no_ack;
        logic        exp_pass, exp_to;
        logic [15:0] exp_err;
        logic [31:0] exp_first;
    } vec_t;

    typedef struct { logic [31:0] a; logic [127:0] d; } wr_t;

    int vectors = 0, miscompares = 0;
    int lat = 3, e1w = -1, e1b = 0, e2w = -1, e2b = 0, no_ack = 0, wr_seen = 0;
    int cnt = 0, w = 0, run_len = 0, last_run = 0;
    wr_t          wr_q[$];
    logic [31:0]  rd_q[$];
    logic [127:0] mem [NW];
    vec_t         vecs [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_step(input logic [31:0] s);
        logic [31:0] r;
        r = {1'b0, s[31:1]};
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic logic [127:0] m_pat(input logic [31:0] s);
        logic [127:0] v;
        logic [63:0]  d;
        for (int k = 0; k < 4; k++) begin
            d = {s, s} << (8 * k);
            v[32*k +: 32] = d[63:32] ^ {4{8'(k)}};
        end
        return v;
    endfunction

    function automatic logic [127:0] flip(input int wi);
        logic [127:0] f;
        f = '0;
        if (wi == e1w) f[e1b] = 1'b1;
        if (wi == e2w) f[e2b] = ~f[e2b];
        return f;
    endfunction

    // Wishbone slave: acks after `lat` strobe cycles, checks writes against the queue.
    initial begin
        forever begin
            @(negedge user_clk_i);
            if (rst_i || ack_i) begin
                ack_i = 1'b0;
                cnt = 0;
            end else if (cyc_o && stb_o) begin
                cnt++;
                if (cnt >= lat && !(we_o && no_ack != 0 && wr_seen == no_ack - 1)) begin
                    ack_i = 1'b1;
                    w = int'(addr_o >> 4) % NW;
                    if (we_o) begin
                        wr_t e;
                        wr_seen++;
                        mem[w] = data_o;
                        if (wr_q.size() == 0) chk("wr_q_underflow", 128'd0, 128'd1);
                        else begin
                            e = wr_q.pop_front();
                            chk("wr_addr", 128'(addr_o), 128'(e.a));
                            chk("wr_data", data_o, e.d);
                        end
                    end else begin
                        data_i = mem[w] ^ flip(w);
                        if (rd_q.size() == 0) chk("rd_q_underflow", 128'd0, 128'd1);
                        else chk("rd_addr", 128'(addr_o), 128'(rd_q.pop_front()));
                    end
                end
            end else cnt = 0;
        end
    end

    // Length of the most recent contiguous stb_o-high stretch, in cycles.
    initial begin
        forever begin
            @(negedge user_clk_i);
            if (rst_i) run_len = 0;
            else if (stb_o) run_len++;
            else if (run_len != 0) begin
                last_run = run_len;
                run_len = 0;
            end
        end
    end

    task automatic set_mode(input vec_t v);
        lat = v.lat; e1w = v.e1w; e1b = v.e1b; e2w = v.e2w; e2b = v.e2b;
        no_ack = v.no_ack; wr_seen = 0;
    endtask

    task automatic push_expected();
        logic [31:0] s;
        s = TB_SEED;
        wr_q.delete();
        rd_q.delete();
        for (int i = 0; i < NW; i++) begin
            wr_q.push_back('{a: 32'(i * 16), d: m_pat(s)});
            rd_q.push_back(32'(i * 16));
            s = m_step(s);
        end
    endtask

    task automatic pulse_start();
        @(negedge user_clk_i);
        start_i = 1'b1;
        @(negedge user_clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done_o && n < 4000) begin
            @(negedge user_clk_i);
            n++;
        end
        if (!done_o) chk({name, "_done_budget"}, 128'(done_o), 128'd1);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        string nm;
        nm = $sformatf("v%0d", i);
        set_mode(v);
        push_expected();
        pulse_start();
        chk({nm, "_busy_n1"}, 128'(busy_o), 128'd1);
        chk({nm, "_stb_n1"}, 128'(stb_o), 128'd0);
        chk({nm, "_cleared_err"}, 128'(err_count_o), 128'd0);
        chk({nm, "_cleared_to"}, 128'(timeout_o), 128'd0);
        @(negedge user_clk_i);
        chk({nm, "_stb_n2"}, 128'(stb_o), 128'd1);
        wait_done(nm);
        @(negedge user_clk_i);
        chk({nm, "_done"}, 128'(done_o), 128'd1);
        chk({nm, "_busy"}, 128'(busy_o), 128'd0);
        chk({nm, "_pass"}, 128'(pass_o), 128'(v.exp_pass));
        chk({nm, "_fail"}, 128'(fail_o), 128'(!v.exp_pass));
        chk({nm, "_timeout"}, 128'(timeout_o), 128'(v.exp_to));
        chk({nm, "_err"}, 128'(err_count_o), 128'(v.exp_err));
        chk({nm, "_first"}, 128'(first_err_addr_o), 128'(v.exp_first));
        chk({nm, "_stb_len"}, 128'(last_run), 128'(v.exp_to ? 50 : v.lat));
        if (!v.exp_to) chk({nm, "_sb_left"}, 128'(wr_q.size() + rd_q.size()), 128'd0);
        wr_q.delete();
        rd_q.delete();
    endtask

    initial begin
        bit saw;
        int n;
        //         lat e1w e1b e2w e2b noack pass to  err    first
        vecs[0] = '{3, -1,  0, -1,   0, 0, 1'b1, 1'b0, 16'd0, 32'h00};
        vecs[1] = '{1, -1,  0, -1,   0, 0, 1'b1, 1'b0, 16'd0, 32'h00};
        vecs[2] = '{3,  3,  5,  6, 127, 0, 1'b0, 1'b0, 16'd2, 32'h30};
        vecs[3] = '{2,  7, 64, -1,   0, 0, 1'b0, 1'b0, 16'd1, 32'h70};
        vecs[4] = '{3,  0,  0,  0,  31, 0, 1'b0, 1'b0, 16'd1, 32'h00};
        vecs[5] = '{3, -1,  0, -1,   0, 2, 1'b0, 1'b1, 16'd0, 32'h00};

        repeat (3) @(negedge user_clk_i);
        chk("rst_busy", 128'(busy_o), 128'd0);
        chk("rst_done", 128'(done_o), 128'd0);
        chk("rst_bus", 128'({cyc_o, stb_o, we_o}), 128'd0);
        chk("rst_addr", 128'(addr_o), 128'd0);
        chk("rst_data", data_o, 128'd0);
        chk("rst_result", 128'({pass_o, fail_o, timeout_o}), 128'd0);
        chk("rst_err", 128'({err_count_o, first_err_addr_o}), 128'd0);
        rst_i = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Calibration held low, then dropped again mid-run.
        set_mode(vecs[0]);
        push_expected();
        calib_done_i = 1'b0;
        pulse_start();
        saw = 1'b0;
        repeat (100) begin
            @(negedge user_clk_i);
            saw |= stb_o;
        end
        chk("calib_no_stb", 128'(saw), 128'd0);
        chk("calib_busy", 128'(busy_o), 128'd1);
        calib_done_i = 1'b1;
        @(negedge user_clk_i);
        chk("calib_stb_rise", 128'(stb_o), 128'd1);
        calib_done_i = 1'b0;
        wait_done("calib");
        chk("calib_pass", 128'(pass_o), 128'd1);
        chk("calib_sb_left", 128'(wr_q.size() + rd_q.size()), 128'd0);
        calib_done_i = 1'b1;

        // start_i while busy must not restart the sequence.
        set_mode(vecs[0]);
        push_expected();
        pulse_start();
        repeat (30) @(negedge user_clk_i);
        pulse_start();
        repeat (50) @(negedge user_clk_i);
        pulse_start();
        wait_done("busy_start");
        chk("busy_start_pass", 128'(pass_o), 128'd1);
        chk("busy_start_sb_left", 128'(wr_q.size() + rd_q.size()), 128'd0);

        // Reset during a read strobe, then a clean run.
        set_mode(vecs[0]);
        push_expected();
        pulse_start();
        n = 0;
        while (!(stb_o && !we_o) && n < 2000) begin
            @(negedge user_clk_i);
            n++;
        end
        chk("mid_rst_found_rd", 128'(stb_o && !we_o), 128'd1);
        rst_i = 1'b1;
        @(negedge user_clk_i);
        chk("mid_rst_bus", 128'({cyc_o, stb_o, we_o}), 128'd0);
        chk("mid_rst_status", 128'({busy_o, done_o, pass_o, fail_o, timeout_o}), 128'd0);
        chk("mid_rst_addr", 128'(addr_o), 128'd0);
        rst_i = 1'b0;
        wr_q.delete();
        rd_q.delete();
        run_vec(6, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
